serial_subtractor: RTL and testbench

Bit-serial WIDTH-bit subtractor computing DIFF = A − B − BORROW_IN one bit per clock, LSB first, through a single registered borrow. It is the subtracting counterpart to the team's combinational one-bit adder. It serves area-constrained datapaths in the lab designs, where a multi-cycle start/done arithmetic unit is preferred over a ripple chain. Operands are captured on START, and results are held stable after DONE until the next accepted START.

---
 rtl/serial_subtractor_pkg.sv | 12 +
 rtl/serial_subtractor_full_subtractor.sv | 13 +
 rtl/serial_subtractor.sv | 160 ++++++++++++++++
 tb/tb_serial_subtractor.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/serial_subtractor_pkg.sv
// Shared types and limits for the bit-serial subtractor.
package serial_subtractor_pkg;

    localparam int unsigned WIDTH_MAX = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage : serial_subtractor_pkg

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit combinational full subtractor: diff = a - b - borrow_in.
module full_subtractor (
    input  logic i_a,
    input  logic i_b,
    input  logic i_borrow_in,
    output logic o_diff_c,
    output logic o_borrow_out_c
);

    assign o_diff_c       = i_a ^ i_b ^ i_borrow_in;
    assign o_borrow_out_c = (~i_a & i_b) | (~i_a & i_borrow_in) | (i_b & i_borrow_in);

endmodule : full_subtractor

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor, LSB first, one bit per clock through a single borrow flop.
// Optional signed-overflow output enabled by defining OVERFLOW_DETECT_EN.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_borrow_in,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_diff,
    output logic             o_borrow_out
`ifdef OVERFLOW_DETECT_EN
    ,
    output logic             o_overflow
`endif
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t             r_state;
    state_t             w_next_state;
    logic               w_load;
    logic               w_shift;
    logic               w_last;

    logic [WIDTH-1:0]   r_a_sr;
    logic [WIDTH-1:0]   r_b_sr;
    logic [WIDTH-1:0]   r_res_sr;
    logic               r_br;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_diff;
    logic               r_borrow_out;

    logic               w_d;
    logic               w_br_next;
    logic [WIDTH-1:0]   w_res_next;

    // Per-bit cell fed from the operand shift-register LSBs and the borrow flop.
    full_subtractor u_cell (
        .i_a            (r_a_sr[0]),
        .i_b            (r_b_sr[0]),
        .i_borrow_in    (r_br),
        .o_diff_c       (w_d),
        .o_borrow_out_c (w_br_next)
    );

    assign w_res_next = {w_d, r_res_sr[WIDTH-1:1]};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_shift      = 1'b0;
        w_last       = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_start) begin
                    w_load       = 1'b1;
                    w_next_state = SHIFT;
                end
            end
            SHIFT: begin
                w_shift = 1'b1;
                if (r_cnt == CNT_W'(WIDTH - 1)) begin
                    w_last       = 1'b1;
                    w_next_state = DONE;
                end
            end
            DONE: begin
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Datapath: capture on accept, shift per bit, publish result on the last bit.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_a_sr       <= '0;
            r_b_sr       <= '0;
            r_res_sr     <= '0;
            r_br         <= 1'b0;
            r_cnt        <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_diff       <= '0;
            r_borrow_out <= 1'b0;
        end else begin
            r_busy <= (w_next_state != IDLE);
            r_done <= (w_next_state == DONE);
            if (w_load) begin
                r_a_sr   <= i_a;
                r_b_sr   <= i_b;
                r_res_sr <= '0;
                r_br     <= i_borrow_in;
                r_cnt    <= '0;
            end else if (w_shift) begin
                r_a_sr   <= {1'b0, r_a_sr[WIDTH-1:1]};
                r_b_sr   <= {1'b0, r_b_sr[WIDTH-1:1]};
                r_res_sr <= w_res_next;
                r_br     <= w_br_next;
                if (!w_last) begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end
            if (w_last) begin
                r_diff       <= w_res_next;
                r_borrow_out <= w_br_next;
            end
        end
    end

    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_diff       = r_diff;
    assign o_borrow_out = r_borrow_out;

`ifdef OVERFLOW_DETECT_EN
    logic r_a_msb;
    logic r_b_msb;
    logic r_overflow;

    // Operand sign bits are kept aside since the shift registers lose them.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_a_msb    <= 1'b0;
            r_b_msb    <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_load) begin
                r_a_msb <= i_a[WIDTH-1];
                r_b_msb <= i_b[WIDTH-1];
            end
            if (w_last) begin
                r_overflow <= (r_a_msb != r_b_msb) && (w_d != r_a_msb);
            end
        end
    end

    assign o_overflow = r_overflow;
`endif

endmodule : serial_subtractor

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed cases plus randomized operands vs. an arithmetic model.
module tb_serial_subtractor;

    localparam int unsigned W = 8;
    localparam int unsigned MAX_WAIT = 40;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         bout;
`ifdef OVERFLOW_DETECT_EN
    logic         ovf;
`endif

    int tests;
    int fails;

    serial_subtractor #(.WIDTH(W)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_start      (start),
        .i_a          (a),
        .i_b          (b),
        .i_borrow_in  (bin),
        .o_busy       (busy),
        .o_done       (done),
        .o_diff       (diff),
        .o_borrow_out (bout)
`ifdef OVERFLOW_DETECT_EN
        ,
        .o_overflow   (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: plain integer arithmetic on the operands.
    function automatic logic [W-1:0] ref_diff(input int unsigned x, input int unsigned y, input int unsigned c);
        longint r;
        r = longint'(x) - longint'(y) - longint'(c);
        return W'(r & ((64'd1 << W) - 1));
    endfunction

    function automatic logic ref_borrow(input int unsigned x, input int unsigned y, input int unsigned c);
        return (longint'(x) < longint'(y) + longint'(c));
    endfunction

    function automatic logic ref_ovf(input int unsigned x, input int unsigned y, input int unsigned c);
        longint sx, sy, r;
        sx = (x >= (1 << (W - 1))) ? longint'(x) - (longint'(1) << W) : longint'(x);
        sy = (y >= (1 << (W - 1))) ? longint'(y) - (longint'(1) << W) : longint'(y);
        r  = sx - sy - longint'(c);
        return (r < -(longint'(1) << (W - 1))) || (r > (longint'(1) << (W - 1)) - 1);
    endfunction

    // Pulse START for one cycle, wait for DONE, check latency and results.
    task automatic run_op(input string tag, input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xc);
        int cyc;
        a = xa; b = xb; bin = xc; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
        check({tag, "_busy_rise"}, 32'(busy), 32'd1);
        cyc = 0;
        while (done !== 1'b1 && cyc < MAX_WAIT) begin
            @(posedge clk); #1;
            cyc++;
        end
        check({tag, "_latency"}, 32'(cyc), 32'(W));
        check({tag, "_diff"}, 32'(diff), 32'(ref_diff(xa, xb, xc)));
        check({tag, "_borrow"}, 32'(bout), 32'(ref_borrow(xa, xb, xc)));
`ifdef OVERFLOW_DETECT_EN
        check({tag, "_ovf"}, 32'(ovf), 32'(ref_ovf(xa, xb, xc)));
`endif
        // START during the DONE cycle must be ignored.
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
        check({tag, "_busy_fall"}, 32'(busy), 32'd0);
        @(posedge clk); #1;
        check({tag, "_no_restart"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int ndone;
        logic [W-1:0] hold;
        tests = 0; fails = 0;
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; bin = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_diff", 32'(diff), 32'd0);
        check("rst_borrow", 32'(bout), 32'd0);
`ifdef OVERFLOW_DETECT_EN
        check("rst_ovf", 32'(ovf), 32'd0);
`endif
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op("d100_37", 8'd100, 8'd37, 1'b0);
        check("d100_37_const", 32'(diff), 32'd63);
        run_op("d5_9", 8'd5, 8'd9, 1'b0);
        check("d5_9_const", 32'(diff), 32'hFC);

        // Result holds through idle cycles while inputs wander.
        hold = diff;
        for (int i = 0; i < 10; i++) begin
            a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
            @(posedge clk); #1;
        end
        check("hold_diff", 32'(diff), 32'(hold));
        check("hold_borrow", 32'(bout), 32'd1);

        run_op("d0_0_b1", 8'd0, 8'd0, 1'b1);
        check("d0_0_b1_const", 32'(diff), 32'hFF);
        run_op("d80_01", 8'h80, 8'h01, 1'b0);
        check("d80_01_const", 32'(diff), 32'h7F);
        run_op("d10_01", 8'h10, 8'h01, 1'b0);
        run_op("dff_ff_b1", 8'hFF, 8'hFF, 1'b1);
        run_op("d7f_ff", 8'h7F, 8'hFF, 1'b0);

        // START re-pulsed mid-operation with other operands is ignored.
        a = 8'd200; b = 8'd13; bin = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        ndone = 0;
        for (int i = 1; i <= int'(W) + 4; i++) begin
            if (i == 3) begin
                a = 8'd1; b = 8'd2; bin = 1'b0; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            if (done === 1'b1) ndone++;
        end
        start = 1'b0;
        check("restart_ndone", 32'(ndone), 32'd1);
        check("restart_diff", 32'(diff), 32'(ref_diff(200, 13, 1)));
        check("restart_busy", 32'(busy), 32'd0);

        // Reset mid-operation aborts with no DONE and cleared results.
        a = 8'd3; b = 8'd250; bin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_diff", 32'(diff), 32'd0);
        check("abort_borrow", 32'(bout), 32'd0);
        ndone = 0;
        repeat (2) begin
            @(posedge clk); #1;
            if (done === 1'b1) ndone++;
        end
        rst_n = 1'b1;
        repeat (int'(W) + 2) begin
            @(posedge clk); #1;
            if (done === 1'b1) ndone++;
        end
        check("abort_ndone", 32'(ndone), 32'd0);
        run_op("after_abort", 8'd3, 8'd250, 1'b0);

        // Randomized operands against the model.
        for (int i = 0; i < 20; i++) begin
            run_op($sformatf("rand%0d", i), W'($urandom), W'($urandom), 1'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_serial_subtractor
